// File: rtl/boolean_expr_driver.sv
// Exhaustive stimulus/response checker for the five-input boolean expression unit.
// Walks vectors 0..31, waits SETTLE_CYCLES, samples y_in and compares against a golden model.
module boolean_expr_driver #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  output logic       d_out,
  output logic       e_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_count,
  output logic [4:0] fail_vec,
  output logic       fail_valid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state_r, state_s;
  logic [4:0] vec_r, vec_s;
  logic [3:0] cnt_r, cnt_s;
  logic [5:0] err_r, err_s;
  logic [4:0] fvec_r, fvec_s;
  logic       fvalid_r, fvalid_s;
  logic       busy_r, done_r, pass_r;

  // Reference response for vector {A,B,C,D,E}
  function automatic logic golden_y(input logic [4:0] v);
    logic a, b, c, d, e;
    {a, b, c, d, e} = v;
    return (a | b | c) | (a & b & e) | (~b & c) | (c & ~d);
  endfunction

  // Next-state and datapath update; abort overrides everything else
  always_comb begin
    state_s  = state_r;
    vec_s    = vec_r;
    cnt_s    = cnt_r;
    err_s    = err_r;
    fvec_s   = fvec_r;
    fvalid_s = fvalid_r;
    if (abort) begin
      state_s = IDLE;
      vec_s   = 5'd0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            vec_s    = 5'd0;
            err_s    = 6'd0;
            fvec_s   = 5'd0;
            fvalid_s = 1'b0;
            cnt_s    = CNT_LOAD;
            state_s  = SETTLE;
          end else begin
            state_s = state_r;
          end
        end
        SETTLE: begin
          if (cnt_r == 4'd0) begin
            state_s = SAMPLE;
          end else begin
            cnt_s = cnt_r - 4'd1;
          end
        end
        SAMPLE: begin
          if (y_in != golden_y(vec_r)) begin
            err_s = err_r + 6'd1;
            if (!fvalid_r) begin
              fvec_s   = vec_r;
              fvalid_s = 1'b1;
            end else begin
              fvalid_s = fvalid_r;
            end
          end else begin
            err_s = err_r;
          end
          // The last vector is held on the outputs once the run completes
          if (vec_r == 5'd31) begin
            state_s = DONE;
          end else begin
            vec_s   = vec_r + 5'd1;
            cnt_s   = CNT_LOAD;
            state_s = SETTLE;
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // State, datapath and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      vec_r    <= 5'd0;
      cnt_r    <= 4'd0;
      err_r    <= 6'd0;
      fvec_r   <= 5'd0;
      fvalid_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      pass_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      vec_r    <= vec_s;
      cnt_r    <= cnt_s;
      err_r    <= err_s;
      fvec_r   <= fvec_s;
      fvalid_r <= fvalid_s;
      busy_r   <= (state_s == SETTLE) || (state_s == SAMPLE);
      done_r   <= (state_s == DONE);
      pass_r   <= (state_s == DONE) && (err_s == 6'd0);
    end
  end

  assign {a_out, b_out, c_out, d_out, e_out} = vec_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign pass       = pass_r;
  assign err_count  = err_r;
  assign fail_vec   = fvec_r;
  assign fail_valid = fvalid_r;

endmodule

// File: tb/tb_boolean_expr_driver.sv
// Directed self-checking bench for boolean_expr_driver: default and SETTLE_CYCLES=1 instances
// driven by a behavioural unit model whose response can be forced wrong.
module tb_boolean_expr_driver;

  logic       clk, rst_n, start, abort;
  logic       y_in, a, b, c, d, e, busy, done, pass, fail_valid;
  logic [5:0] err_count;
  logic [4:0] fail_vec;

  logic       start1, abort1, y1, a1, b1, c1, d1, e1, busy1, done1, pass1, fail_valid1;
  logic [5:0] err_count1;
  logic [4:0] fail_vec1;

  int mode;  // 0 correct unit, 1 y tied 0, 2 y tied 1, 3 inverted
  int checks = 0;
  int failures = 0;
  int cycles;

  function automatic logic unit_y(input logic [4:0] v);
    logic va, vb, vc, vd, ve;
    {va, vb, vc, vd, ve} = v;
    return (va | vb | vc) | (va & vb & ve) | (~vb & vc) | (vc & ~vd);
  endfunction

  always_comb begin
    case (mode)
      1:       y_in = 1'b0;
      2:       y_in = 1'b1;
      3:       y_in = ~unit_y({a, b, c, d, e});
      default: y_in = unit_y({a, b, c, d, e});
    endcase
  end
  assign y1 = unit_y({a1, b1, c1, d1, e1});

  boolean_expr_driver dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .y_in(y_in),
    .a_out(a), .b_out(b), .c_out(c), .d_out(d), .e_out(e),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_vec(fail_vec), .fail_valid(fail_valid)
  );

  boolean_expr_driver #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .y_in(y1),
    .a_out(a1), .b_out(b1), .c_out(c1), .d_out(d1), .e_out(e1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1),
    .fail_vec(fail_vec1), .fail_valid(fail_valid1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start, then count cycles until done (bounded); optionally re-pulse start mid-run
  task automatic run(input int pulse_at, output int n);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("busy_after_start", 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 400) begin
      start = (n == pulse_at);
      tick();
      n++;
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; start1 = 1'b0; abort1 = 1'b0; mode = 0;
    #12;
    check_eq("rst_drive", 32'({a, b, c, d, e}), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_pass", 32'(pass), 32'd0);
    check_eq("rst_err", 32'(err_count), 32'd0);
    check_eq("rst_fvalid", 32'(fail_valid), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Correct unit
    run(-1, cycles);
    check_eq("ok_cycles", 32'(cycles), 32'd160);
    check_eq("ok_pass", 32'(pass), 32'd1);
    check_eq("ok_err", 32'(err_count), 32'd0);
    check_eq("ok_fvalid", 32'(fail_valid), 32'd0);
    check_eq("ok_drive", 32'({a, b, c, d, e}), 32'd31);
    check_eq("ok_busy", 32'(busy), 32'd0);
    repeat (5) tick();
    check_eq("ok_done_held", 32'(done), 32'd1);

    // y tied 0
    mode = 1;
    run(-1, cycles);
    check_eq("t0_cycles", 32'(cycles), 32'd160);
    check_eq("t0_err", 32'(err_count), 32'd28);
    check_eq("t0_fvec", 32'(fail_vec), 32'd4);
    check_eq("t0_fvalid", 32'(fail_valid), 32'd1);
    check_eq("t0_pass", 32'(pass), 32'd0);

    // y tied 1
    mode = 2;
    run(-1, cycles);
    check_eq("t1_err", 32'(err_count), 32'd4);
    check_eq("t1_fvec", 32'(fail_vec), 32'd0);
    check_eq("t1_fvalid", 32'(fail_valid), 32'd1);
    check_eq("t1_pass", 32'(pass), 32'd0);

    // Inverted unit
    mode = 3;
    run(-1, cycles);
    check_eq("inv_err", 32'(err_count), 32'd32);
    check_eq("inv_fvec", 32'(fail_vec), 32'd0);

    // start while busy is ignored
    mode = 0;
    run(50, cycles);
    check_eq("restart_cycles", 32'(cycles), 32'd160);
    check_eq("restart_pass", 32'(pass), 32'd1);

    // abort mid-run keeps results (vectors 0..13 sampled, 4..13 mismatch)
    mode = 1;
    start = 1'b1; tick(); start = 1'b0;
    repeat (70) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_drive", 32'({a, b, c, d, e}), 32'd0);
    check_eq("abort_err", 32'(err_count), 32'd10);
    check_eq("abort_fvec", 32'(fail_vec), 32'd4);
    tick();
    check_eq("abort_idle", 32'(busy), 32'd0);

    // start and abort together stay idle
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    check_eq("both_busy", 32'(busy), 32'd0);
    tick();
    check_eq("both_idle", 32'(busy), 32'd0);

    // asynchronous reset mid-SETTLE (vec 2, two mismatches already)
    mode = 3;
    start = 1'b1; tick(); start = 1'b0;
    repeat (12) tick();
    check_eq("pre_rst_err", 32'(err_count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_drive", 32'({a, b, c, d, e}), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_err", 32'(err_count), 32'd0);
    check_eq("arst_fvalid", 32'(fail_valid), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    mode = 0;
    run(-1, cycles);
    check_eq("post_rst_cycles", 32'(cycles), 32'd160);
    check_eq("post_rst_pass", 32'(pass), 32'd1);

    // SETTLE_CYCLES=1: two cycles per vector, done 64 cycles after start
    start1 = 1'b1; tick(); start1 = 1'b0;
    for (int k = 0; k <= 64; k++) begin
      check_eq("s1_vec", 32'({a1, b1, c1, d1, e1}), (k < 64) ? 32'(k / 2) : 32'd31);
      check_eq("s1_done", 32'(done1), (k == 64) ? 32'd1 : 32'd0);
      if (k < 64) tick();
    end
    check_eq("s1_pass", 32'(pass1), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/boolean_expr_driver.md
Name: boolean_expr_driver

Overview:
Sequential stimulus and response-checking block for the five-input boolean expression unit (inputs A..E, output Y). It is the driving and sampling end of that unit's interface. It walks all 32 input vectors, waits a programmable settle time for the unit's gate delays, samples Y, and compares it against an internal golden model. It reports a mismatch count, the first failing vector, and pass/done status. It is used in self-checking simulation and as a built-in exhaustive test at board bring-up.

Parameters:
SETTLE_CYCLES, 4, clock cycles between applying a vector and sampling y_in; legal range 1..15. SETTLE_CYCLES times the clock period must exceed the unit's worst-case propagation delay (13 time units).

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin an exhaustive run; sampled only in IDLE or DONE
abort  input  1  stop the current run and return to IDLE
y_in  input  1  Y from the unit under test
a_out, b_out, c_out, d_out, e_out  output  1 each  drive A..E; registered
busy  output  1  high in SETTLE and SAMPLE
done  output  1  high in DONE; held until the next start or abort
pass  output  1  done AND err_count==0
err_count  output  6  number of mismatching vectors, 0..32
fail_vec  output  5  {A,B,C,D,E} of the first mismatch
fail_valid  output  1  fail_vec holds a captured vector

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - All drive outputs 0, vec=0, settle counter 0.
  - busy=0, done=0, pass=0, err_count=0, fail_vec=0, fail_valid=0.
- Vector encoding:
  - vec[4:0] = {A,B,C,D,E}, A is the MSB.
  - Vectors are applied in order 0..31.
  - Drive outputs always equal vec bits.
- Golden model: Y_exp = (A|B|C) | (A&B&E) | (~B&C) | (C&~D), evaluated on the registered vec.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE or DONE with start=1 and abort=0:
  - vec<=0, err_count<=0, fail_valid<=0, fail_vec<=0, done<=0.
  - cnt<=SETTLE_CYCLES-1, state<=SETTLE.
- SETTLE:
  - if cnt==0, state<=SAMPLE; else cnt<=cnt-1.
  - Occupies exactly SETTLE_CYCLES cycles.
- SAMPLE (1 cycle): compare y_in with Y_exp.
  - On mismatch: err_count<=err_count+1.
  - If fail_valid==0 on that mismatch: fail_vec<=vec, fail_valid<=1.
  - If vec==31: state<=DONE and vec is held (no wrap to 0).
  - Otherwise: vec<=vec+1, cnt<=SETTLE_CYCLES-1, state<=SETTLE.
- Timing:
  - Each vector takes SETTLE_CYCLES+1 cycles.
  - done rises exactly 32*(SETTLE_CYCLES+1) cycles after the edge that sampled start (160 cycles at default).
- DONE:
  - done=1; pass=(err_count==0).
  - Results are held stable until a new start or abort.
  - A new start restarts the run and clears results on the same edge.
- start while busy: ignored; the run is unaffected.
- abort, any state:
  - Next edge: state<=IDLE, vec<=0, busy=0, done=0.
  - err_count, fail_vec and fail_valid are retained for debug.
  - abort takes priority over start on the same edge.
- err_count is 6 bits so the maximum of 32 never overflows; no saturation logic is needed.
- Reset asserted mid-run: immediate return to the reset values above; no partial results survive.
- y_in is treated as synchronous. The bench or integration guarantees that the settle time covers propagation; no synchronizer is included.

Test Plan:
- Correct unit connected, default parameter, start pulse -> busy high for 160 cycles, then done=1, pass=1, err_count=0, fail_valid=0; drive outputs end at 5'b11111.
- y_in tied 0 -> err_count=28 (every vector with A|B|C=1), fail_vec=5'b00100, fail_valid=1, pass=0.
- y_in tied 1 -> err_count=4 (vectors 0..3), fail_vec=5'b00000, pass=0. A y_in equal to the inverted golden output -> err_count=32, fail_vec=0.
- SETTLE_CYCLES=1 -> done exactly 64 cycles after start; each vector is held 2 cycles; the vector sequence is checked cycle by cycle.
- start pulsed again at cycle 50 of a run -> ignored, done still at 160. abort at cycle 70 -> IDLE next cycle, done=0, drive outputs 0, err_count retained. start and abort on the same edge -> stays IDLE.
- rst_n pulled low asynchronously mid-SETTLE (between clock edges) -> all outputs 0 immediately. A fresh start after release produces a full 160-cycle run with correct results.
